// File: rtl/gcc_pkg.sv
// Shared types and width helpers for the weighted-centroid calculator.
//   gcc_state_e : top-level controller states (accumulate, divide, output)
//   calc_sumw   : width of the SX/SY/SW accumulators
//   calc_dw     : divider width and iteration count (one spare bit for the round bias)
package gcc_pkg;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    DIV = 2'd1,
    OUT = 2'd2
  } gcc_state_e;

  function automatic int calc_sumw(input int xw, input int ww, input int npts);
    return xw + ww + $clog2(npts);
  endfunction

  function automatic int calc_dw(input int xw, input int ww, input int npts);
    return calc_sumw(xw, ww, npts) + 1;
  endfunction

endpackage

// File: rtl/gcc_seqdiv.sv
// Sequential restoring divider, one quotient bit per clock, DW clocks per divide.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous reset, active-low
//   start_i    load dividend/divisor and begin (ignored only by reset)
//   dividend_i DW-bit unsigned dividend
//   divisor_i  DW-bit unsigned divisor
//   busy_o     an iteration is pending
//   done_o     high in the cycle whose clock edge completes the last iteration
//   quot_o     low QW bits of the quotient after that edge (valid with done_o)
//   dz_o       divisor of the running divide is zero; quot_o is then forced to 0
module gcc_seqdiv #(
  parameter int DW = 15,
  parameter int QW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [QW-1:0] quot_o,
  output logic          dz_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;   // shifts dividend bits out at the top, quotient bits in
  logic [DW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          dz_q;

  logic [DW:0]   rem_sh;
  logic [DW-1:0] diff;
  logic          ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[DW-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    // Only used when ge, so the result always fits in DW bits.
    diff   = rem_sh[DW-1:0] - dvs_q;
    rem_d  = ge ? diff : rem_sh[DW-1:0];
    quo_d  = {quo_q[DW-2:0], ge};
  end

  assign busy_o = busy_q;
  assign dz_o   = dz_q;
  assign done_o = busy_q && (cnt_q == CW'(DW - 1));
  // Quotient as it will be after the current edge, so the caller can register it
  // on the very edge that finishes the divide.
  assign quot_o = dz_q ? '0 : quo_d[QW-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      dz_q   <= (divisor_i == '0);
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gcc_wcentroid.sv
// Weighted centroid of every NPTS accepted points: Xc=SX/SW, Yc=SY/SW.
// Ports:
//   CLK       clock
//   RESET_    synchronous reset, active-low, overrides everything
//   IN_VALID  Xi/Yi/Wi carry a point this cycle
//   IN_RDY    point accepted this cycle if IN_VALID (only while accumulating)
//   Xi, Yi    unsigned point coordinates (XW bits)
//   Wi        unsigned point weight (WW bits, 0 allowed)
//   Xc, Yc    registered centroid, held until the next result
//   ZW        total weight of the group behind Xc/Yc was zero
//   READY_    active-low one-cycle result strobe
module gcc_wcentroid
  import gcc_pkg::*;
#(
  parameter int XW    = 8,
  parameter int WW    = 4,
  parameter int NPTS  = 3,
  parameter int ROUND = 0
) (
  input  logic          CLK,
  input  logic          RESET_,
  input  logic          IN_VALID,
  output logic          IN_RDY,
  input  logic [XW-1:0] Xi,
  input  logic [XW-1:0] Yi,
  input  logic [WW-1:0] Wi,
  output logic [XW-1:0] Xc,
  output logic [XW-1:0] Yc,
  output logic          ZW,
  output logic          READY_
);

  localparam int SUMW = calc_sumw(XW, WW, NPTS);
  localparam int DW   = calc_dw(XW, WW, NPTS);
  localparam int CNTW = $clog2(NPTS);

  gcc_state_e state_q, state_d;

  logic [CNTW-1:0]  cnt_q;
  logic [SUMW-1:0]  sx_q, sy_q, sw_q;
  logic [XW-1:0]    xc_q, yc_q;
  logic             zw_q;

  logic             accept, last_pt;
  logic [XW+WW-1:0] prod_x, prod_y;
  logic [SUMW-1:0]  sx_new, sy_new, sw_new, bias;
  logic [DW-1:0]    x_dividend, y_dividend, divisor;

  logic             x_busy, y_busy, x_done, y_done, x_dz, y_dz;
  logic [XW-1:0]    x_quot, y_quot;

  assign accept  = (state_q == ACC) && IN_VALID;
  assign last_pt = accept && (cnt_q == CNTW'(NPTS - 1));

  // Sums including the point presented this cycle; they feed both the
  // accumulators and, on the last point, the dividers directly.
  always_comb begin
    prod_x     = Xi * Wi;
    prod_y     = Yi * Wi;
    sx_new     = sx_q + SUMW'(prod_x);
    sy_new     = sy_q + SUMW'(prod_y);
    sw_new     = sw_q + SUMW'(Wi);
    // Adding floor(SW/2) before a floor divide gives round-half-up.
    bias       = (ROUND != 0) ? (sw_new >> 1) : '0;
    x_dividend = DW'(sx_new) + DW'(bias);
    y_dividend = DW'(sy_new) + DW'(bias);
    divisor    = DW'(sw_new);
  end

  gcc_seqdiv #(.DW(DW), .QW(XW)) u_div_x (
    .clk_i      (CLK),
    .rst_ni     (RESET_),
    .start_i    (last_pt),
    .dividend_i (x_dividend),
    .divisor_i  (divisor),
    .busy_o     (x_busy),
    .done_o     (x_done),
    .quot_o     (x_quot),
    .dz_o       (x_dz)
  );

  gcc_seqdiv #(.DW(DW), .QW(XW)) u_div_y (
    .clk_i      (CLK),
    .rst_ni     (RESET_),
    .start_i    (last_pt),
    .dividend_i (y_dividend),
    .divisor_i  (divisor),
    .busy_o     (y_busy),
    .done_o     (y_done),
    .quot_o     (y_quot),
    .dz_o       (y_dz)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC: if (last_pt) state_d = DIV;
      DIV: begin
        if (x_done && y_done) begin
          state_d = OUT;
        end else if (!x_busy || !y_busy) begin
          // Dividers idle while waiting on them: recover rather than hang.
          state_d = ACC;
        end
      end
      OUT:     state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Outputs
  always_comb begin
    IN_RDY = (state_q == ACC);
    READY_ = (state_q != OUT);
    Xc     = xc_q;
    Yc     = yc_q;
    ZW     = zw_q;
  end

  // Accumulators, point counter and result registers
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      sw_q  <= '0;
      xc_q  <= '0;
      yc_q  <= '0;
      zw_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (last_pt) begin
          // Dividers hold their own copy; start the next group clean.
          cnt_q <= '0;
          sx_q  <= '0;
          sy_q  <= '0;
          sw_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNTW'(1);
          sx_q  <= sx_new;
          sy_q  <= sy_new;
          sw_q  <= sw_new;
        end
      end
      if ((state_q == DIV) && x_done && y_done) begin
        xc_q <= x_quot;
        yc_q <= y_quot;
        // Both dividers share the divisor, so their flags agree.
        zw_q <= x_dz | y_dz;
      end
    end
  end

endmodule

// File: tb/tb_gcc_wcentroid.sv
// Directed-vector bench for gcc_wcentroid: default truncating instance, a
// round-half-up instance sharing its inputs, and an NPTS=4/XW=10/WW=6 instance.
module tb_gcc_wcentroid;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET_, IN_VALID;
  logic [7:0] Xi, Yi;
  logic [3:0] Wi;
  logic       rdy0, rdyn0, zw0, rdy1, rdyn1, zw1;
  logic [7:0] xc0, yc0, xc1, yc1;
  logic       v2, rdy2, rdyn2, zw2;
  logic [9:0] x2, y2, xc2, yc2;
  logic [5:0] w2;

  gcc_wcentroid #(.XW(8), .WW(4), .NPTS(3), .ROUND(0)) dut0 (
    .CLK(CLK), .RESET_(RESET_), .IN_VALID(IN_VALID), .IN_RDY(rdy0),
    .Xi(Xi), .Yi(Yi), .Wi(Wi), .Xc(xc0), .Yc(yc0), .ZW(zw0), .READY_(rdyn0));

  gcc_wcentroid #(.XW(8), .WW(4), .NPTS(3), .ROUND(1)) dut1 (
    .CLK(CLK), .RESET_(RESET_), .IN_VALID(IN_VALID), .IN_RDY(rdy1),
    .Xi(Xi), .Yi(Yi), .Wi(Wi), .Xc(xc1), .Yc(yc1), .ZW(zw1), .READY_(rdyn1));

  gcc_wcentroid #(.XW(10), .WW(6), .NPTS(4), .ROUND(0)) dut2 (
    .CLK(CLK), .RESET_(RESET_), .IN_VALID(v2), .IN_RDY(rdy2),
    .Xi(x2), .Yi(y2), .Wi(w2), .Xc(xc2), .Yc(yc2), .ZW(zw2), .READY_(rdyn2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] w;
    bit         gap;
  } pt_t;

  pt_t        pts[$];
  logic [7:0] rx0[$], ry0[$], rz0[$], rx1[$], ry1[$], rz1[$];
  int         rlat[$];
  int         notrdy;

  function automatic logic [7:0] at8(input logic [7:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  function automatic int ati(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic add_pt(input logic [7:0] x, input logic [7:0] y, input logic [3:0] w, input bit gap);
    pt_t p;
    p.x = x; p.y = y; p.w = w; p.gap = gap;
    pts.push_back(p);
  endtask

  // Feeds pts into dut0/dut1 and records every READY_ pulse. hold_valid keeps
  // IN_VALID high with random data whenever the block is not ready.
  task automatic stream(input bit hold_valid);
    int idx = 0, cyc = 0, last_acc = 0;
    bit will, gap_done = 0;
    rx0.delete(); ry0.delete(); rz0.delete(); rx1.delete(); ry1.delete(); rz1.delete();
    rlat.delete(); notrdy = 0;
    while (cyc < 2000) begin
      if (rdyn0 === 1'b0) begin
        rx0.push_back(xc0); ry0.push_back(yc0); rz0.push_back({7'd0, zw0});
        rlat.push_back(cyc - last_acc);
      end
      if (rdyn1 === 1'b0) begin
        rx1.push_back(xc1); ry1.push_back(yc1); rz1.push_back({7'd0, zw1});
      end
      if (rdy0 !== 1'b1) notrdy++;
      if (idx == pts.size() && (cyc - last_acc) > 25) break;
      will = 0;
      if (rdy0 === 1'b1 && idx < pts.size()) begin
        if (pts[idx].gap && !gap_done) begin
          IN_VALID = 1'b0; gap_done = 1;
        end else begin
          IN_VALID = 1'b1; Xi = pts[idx].x; Yi = pts[idx].y; Wi = pts[idx].w; will = 1;
        end
      end else if (hold_valid && rdy0 !== 1'b1) begin
        IN_VALID = 1'b1; Xi = 8'($urandom); Yi = 8'($urandom); Wi = 4'($urandom);
      end else begin
        IN_VALID = 1'b0;
      end
      @(posedge CLK); #1; cyc++;
      if (will) begin idx++; last_acc = cyc; gap_done = 0; end
    end
    IN_VALID = 1'b0;
    pts.delete();
  endtask

  task automatic test_reset();
    RESET_ = 1'b0; IN_VALID = 1'b1; Xi = 8'hFF; Yi = 8'hFF; Wi = 4'hF;
    v2 = 1'b1; x2 = 10'h3FF; y2 = 10'h3FF; w2 = 6'h3F;
    repeat (3) @(posedge CLK); #1;
    checks++; if (rdyn0 !== 1'b1) begin errors++; $display("FAIL reset_ready_n: got %b expected 1", rdyn0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b expected 1", rdy0); end
    checks++; if (xc0 !== 8'h00 || yc0 !== 8'h00) begin errors++; $display("FAIL reset_xy: got %h/%h expected 00/00", xc0, yc0); end
    checks++; if (zw0 !== 1'b0) begin errors++; $display("FAIL reset_zw: got %b expected 0", zw0); end
    checks++; if (rdyn2 !== 1'b1 || xc2 !== 10'd0) begin errors++; $display("FAIL reset_dut2: got %b/%h expected 1/000", rdyn2, xc2); end
    IN_VALID = 1'b0; v2 = 1'b0;
    @(posedge CLK); #1;
    RESET_ = 1'b1;
    @(posedge CLK); #1;
    checks++; if (rdy0 !== 1'b1 || rdyn0 !== 1'b1) begin errors++; $display("FAIL reset_release: got rdy=%b ready_n=%b expected 1/1", rdy0, rdyn0); end
  endtask

  task automatic test_basic();
    add_pt(8'd10, 8'd20, 4'd1, 1'b0); add_pt(8'd20, 8'd40, 4'd1, 1'b0); add_pt(8'd30, 8'd60, 4'd2, 1'b0);
    stream(1'b0);
    checks++; if (rx0.size() != 1 || rx1.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d/%0d expected 1/1", rx0.size(), rx1.size()); end
    checks++; if (at8(rx0, 0) !== 8'h16) begin errors++; $display("FAIL basic_xc_trunc: got %h expected 16", at8(rx0, 0)); end
    checks++; if (at8(ry0, 0) !== 8'h2D) begin errors++; $display("FAIL basic_yc_trunc: got %h expected 2d", at8(ry0, 0)); end
    checks++; if (at8(rz0, 0) !== 8'd0) begin errors++; $display("FAIL basic_zw: got %h expected 00", at8(rz0, 0)); end
    checks++; if (ati(rlat, 0) != 15) begin errors++; $display("FAIL basic_latency: got %0d expected 15", ati(rlat, 0)); end
    checks++; if (at8(rx1, 0) !== 8'h17) begin errors++; $display("FAIL basic_xc_round: got %h expected 17", at8(rx1, 0)); end
    checks++; if (at8(ry1, 0) !== 8'h2D) begin errors++; $display("FAIL basic_yc_round: got %h expected 2d", at8(ry1, 0)); end
  endtask

  task automatic test_zero_weight();
    add_pt(8'd10, 8'd20, 4'd0, 1'b0); add_pt(8'hFF, 8'hFF, 4'd0, 1'b0); add_pt(8'd30, 8'd60, 4'd0, 1'b0);
    stream(1'b0);
    checks++; if (rx0.size() != 1 || rx1.size() != 1) begin errors++; $display("FAIL zero_pulses: got %0d/%0d expected 1/1", rx0.size(), rx1.size()); end
    checks++; if (at8(rx0, 0) !== 8'h00 || at8(ry0, 0) !== 8'h00) begin errors++; $display("FAIL zero_xy: got %h/%h expected 00/00", at8(rx0, 0), at8(ry0, 0)); end
    checks++; if (at8(rz0, 0) !== 8'd1 || at8(rz1, 0) !== 8'd1) begin errors++; $display("FAIL zero_zw: got %h/%h expected 01/01", at8(rz0, 0), at8(rz1, 0)); end
    checks++; if (at8(rx1, 0) !== 8'h00 || at8(ry1, 0) !== 8'h00) begin errors++; $display("FAIL zero_xy_round: got %h/%h expected 00/00", at8(rx1, 0), at8(ry1, 0)); end
    checks++; if (ati(rlat, 0) != 15) begin errors++; $display("FAIL zero_latency: got %0d expected 15", ati(rlat, 0)); end
  endtask

  task automatic test_extremes();
    logic [7:0] ex_x0[2] = '{8'hFF, 8'hEF};
    logic [7:0] ex_y0[2] = '{8'hFF, 8'h0F};
    logic [7:0] ex_y1[2] = '{8'hFF, 8'h10};
    repeat (3) add_pt(8'hFF, 8'hFF, 4'hF, 1'b0);
    add_pt(8'hFF, 8'h00, 4'hF, 1'b0); add_pt(8'h00, 8'hFF, 4'h1, 1'b0); add_pt(8'h00, 8'h00, 4'h0, 1'b0);
    stream(1'b0);
    checks++; if (rx0.size() != 2) begin errors++; $display("FAIL ext_pulses: got %0d expected 2", rx0.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (at8(rx0, i) !== ex_x0[i]) begin errors++; $display("FAIL ext_xc[%0d]: got %h expected %h", i, at8(rx0, i), ex_x0[i]); end
      checks++; if (at8(ry0, i) !== ex_y0[i]) begin errors++; $display("FAIL ext_yc[%0d]: got %h expected %h", i, at8(ry0, i), ex_y0[i]); end
      checks++; if (at8(rx1, i) !== ex_x0[i]) begin errors++; $display("FAIL ext_xc_round[%0d]: got %h expected %h", i, at8(rx1, i), ex_x0[i]); end
      checks++; if (at8(ry1, i) !== ex_y1[i]) begin errors++; $display("FAIL ext_yc_round[%0d]: got %h expected %h", i, at8(ry1, i), ex_y1[i]); end
      checks++; if (at8(rz0, i) !== 8'd0) begin errors++; $display("FAIL ext_zw[%0d]: got %h expected 00", i, at8(rz0, i)); end
    end
  endtask

  task automatic test_hold_valid();
    logic [7:0] ex_x0[2] = '{8'h16, 8'hEF};
    logic [7:0] ex_y0[2] = '{8'h2D, 8'h0F};
    logic [7:0] ex_x1[2] = '{8'h17, 8'hEF};
    logic [7:0] ex_y1[2] = '{8'h2D, 8'h10};
    add_pt(8'd10, 8'd20, 4'd1, 1'b0); add_pt(8'd20, 8'd40, 4'd1, 1'b0); add_pt(8'd30, 8'd60, 4'd2, 1'b0);
    add_pt(8'hFF, 8'h00, 4'hF, 1'b0); add_pt(8'h00, 8'hFF, 4'h1, 1'b0); add_pt(8'h00, 8'h00, 4'h0, 1'b0);
    stream(1'b1);
    checks++; if (notrdy != 32) begin errors++; $display("FAIL hold_not_ready_cycles: got %0d expected 32", notrdy); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (at8(rx0, i) !== ex_x0[i]) begin errors++; $display("FAIL hold_xc[%0d]: got %h expected %h", i, at8(rx0, i), ex_x0[i]); end
      checks++; if (at8(ry0, i) !== ex_y0[i]) begin errors++; $display("FAIL hold_yc[%0d]: got %h expected %h", i, at8(ry0, i), ex_y0[i]); end
      checks++; if (at8(rx1, i) !== ex_x1[i]) begin errors++; $display("FAIL hold_xc_round[%0d]: got %h expected %h", i, at8(rx1, i), ex_x1[i]); end
      checks++; if (at8(ry1, i) !== ex_y1[i]) begin errors++; $display("FAIL hold_yc_round[%0d]: got %h expected %h", i, at8(ry1, i), ex_y1[i]); end
      checks++; if (ati(rlat, i) != 15) begin errors++; $display("FAIL hold_latency[%0d]: got %0d expected 15", i, ati(rlat, i)); end
    end
  endtask

  task automatic test_gaps();
    add_pt(8'd10, 8'd20, 4'd1, 1'b0); add_pt(8'd20, 8'd40, 4'd1, 1'b1); add_pt(8'd30, 8'd60, 4'd2, 1'b1);
    stream(1'b0);
    checks++; if (rx0.size() != 1) begin errors++; $display("FAIL gaps_pulses: got %0d expected 1", rx0.size()); end
    checks++; if (at8(rx0, 0) !== 8'h16 || at8(ry0, 0) !== 8'h2D) begin errors++; $display("FAIL gaps_xy: got %h/%h expected 16/2d", at8(rx0, 0), at8(ry0, 0)); end
    checks++; if (at8(rx1, 0) !== 8'h17) begin errors++; $display("FAIL gaps_xc_round: got %h expected 17", at8(rx1, 0)); end
    checks++; if (ati(rlat, 0) != 15) begin errors++; $display("FAIL gaps_latency: got %0d expected 15", ati(rlat, 0)); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    IN_VALID = 1'b1;
    Xi = 8'd10; Yi = 8'd20; Wi = 4'd1; @(posedge CLK); #1;
    Xi = 8'd20; Yi = 8'd40; Wi = 4'd1; @(posedge CLK); #1;
    Xi = 8'd30; Yi = 8'd60; Wi = 4'd2; @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (6) begin @(posedge CLK); #1; end
    RESET_ = 1'b0; @(posedge CLK); #1; RESET_ = 1'b1;
    checks++; if (rdyn0 !== 1'b1 || rdy0 !== 1'b1) begin errors++; $display("FAIL rdiv_state: got ready_n=%b rdy=%b expected 1/1", rdyn0, rdy0); end
    checks++; if (xc0 !== 8'h00 || yc0 !== 8'h00 || zw0 !== 1'b0) begin errors++; $display("FAIL rdiv_outputs: got %h/%h/%b expected 00/00/0", xc0, yc0, zw0); end
    checks++; if (xc1 !== 8'h00) begin errors++; $display("FAIL rdiv_xc_round: got %h expected 00", xc1); end
    repeat (30) begin @(posedge CLK); #1; if (rdyn0 === 1'b0 || rdyn1 === 1'b0) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rdiv_stale_pulse: got %0d expected 0", pulses); end
    IN_VALID = 1'b1; Xi = 8'hFF; Yi = 8'hFF; Wi = 4'hF;
    repeat (3) begin @(posedge CLK); #1; end
    IN_VALID = 1'b0;
    for (int c = 0; c < 40 && rdyn0 !== 1'b0; c++) begin @(posedge CLK); #1; end
    checks++; if (rdyn0 !== 1'b0 || xc0 !== 8'hFF) begin errors++; $display("FAIL rout_wait: got ready_n=%b xc=%h expected 0/ff", rdyn0, xc0); end
    RESET_ = 1'b0; @(posedge CLK); #1; RESET_ = 1'b1;
    checks++; if (rdyn0 !== 1'b1) begin errors++; $display("FAIL rout_ready_n: got %b expected 1", rdyn0); end
    checks++; if (xc0 !== 8'h00 || yc0 !== 8'h00 || zw0 !== 1'b0) begin errors++; $display("FAIL rout_outputs: got %h/%h/%b expected 00/00/0", xc0, yc0, zw0); end
    add_pt(8'd10, 8'd20, 4'd1, 1'b0); add_pt(8'd20, 8'd40, 4'd1, 1'b0); add_pt(8'd30, 8'd60, 4'd2, 1'b0);
    stream(1'b0);
    checks++; if (rx0.size() != 1 || at8(rx0, 0) !== 8'h16 || at8(ry0, 0) !== 8'h2D) begin errors++; $display("FAIL rafter_xy: got n=%0d %h/%h expected 1 16/2d", rx0.size(), at8(rx0, 0), at8(ry0, 0)); end
    checks++; if (at8(rx1, 0) !== 8'h17 || ati(rlat, 0) != 15) begin errors++; $display("FAIL rafter_round_lat: got %h lat %0d expected 17 lat 15", at8(rx1, 0), ati(rlat, 0)); end
  endtask

  task automatic test_npts4();
    for (int g = 0; g < 40; g++) begin
      int sx = 0, sy = 0, sw = 0, pulses = 0, lat = -1;
      logic [9:0] ex, ey, gx, gy;
      logic gz;
      gx = 'x; gy = 'x; gz = 1'bx;
      for (int p = 0; p < 4; p++) begin
        int xv = $urandom_range(0, 1023);
        int yv = $urandom_range(0, 1023);
        int wv = $urandom_range(0, 63);
        if (g == 0) wv = 0;
        if (g == 1) begin xv = 1023; yv = 1023; wv = 63; end
        sx += xv * wv; sy += yv * wv; sw += wv;
        for (int c = 0; c < 50 && rdy2 !== 1'b1; c++) begin @(posedge CLK); #1; end
        v2 = 1'b1; x2 = 10'(xv); y2 = 10'(yv); w2 = 6'(wv);
        @(posedge CLK); #1;
      end
      v2 = 1'b0;
      ex = (sw == 0) ? 10'd0 : 10'(sx / sw);
      ey = (sw == 0) ? 10'd0 : 10'(sy / sw);
      for (int c = 1; c <= 40; c++) begin
        @(posedge CLK); #1;
        if (rdyn2 === 1'b0) begin
          pulses++;
          if (lat < 0) begin lat = c; gx = xc2; gy = yc2; gz = zw2; end
        end
        if (rdy2 === 1'b1) break;
      end
      checks++; if (pulses != 1 || lat != 19) begin errors++; $display("FAIL n4_pulse[%0d]: got %0d pulses lat %0d expected 1 lat 19", g, pulses, lat); end
      checks++; if (gx !== ex) begin errors++; $display("FAIL n4_xc[%0d]: got %h expected %h", g, gx, ex); end
      checks++; if (gy !== ey) begin errors++; $display("FAIL n4_yc[%0d]: got %h expected %h", g, gy, ey); end
      checks++; if (gz !== (sw == 0)) begin errors++; $display("FAIL n4_zw[%0d]: got %b expected %b", g, gz, (sw == 0)); end
    end
  endtask

  initial begin
    RESET_ = 1'b0; IN_VALID = 1'b0; Xi = '0; Yi = '0; Wi = '0;
    v2 = 1'b0; x2 = '0; y2 = '0; w2 = '0;
    test_reset();
    test_basic();
    test_zero_weight();
    test_extremes();
    test_hold_valid();
    test_gaps();
    test_reset_mid();
    test_npts4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
